// File: rtl/uart_tx_pkg.sv
// Shared types and bit positions for the memory-mapped UART transmitter.
// Status and control bit positions are fixed by the firmware register map.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_ACTIVE    = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTL_FLAG     = 15;
  localparam int CTL_CLR_OVF  = 0;

endpackage

// File: rtl/uart_tx_port_byte_fifo.sv
// Byte FIFO feeding the transmitter. Full/empty are flops so the status word
// seen by the core has no combinational path from the write strobe.
module byte_fifo
  import uart_tx_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          sysclk,
  input  logic          sysreset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is dropped even if a pop lands on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_V);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// UART 8N1 transmitter behind one core register: write decode, sticky
// overflow, byte FIFO and the bit-timing FSM that drives txd.
//
// state   | meaning
// S_IDLE  | line idle high, waiting for a queued byte
// S_START | start bit (low) for CLK_DIV cycles
// S_DATA  | data bits LSB first, CLK_DIV cycles each
// S_STOP  | stop bit (high); last cycle may pop straight into the next frame
module uart_tx_port
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic [15:0] wr_data,
  input  logic        wr_load,
  output logic [15:0] status,
  output logic        txd,
  output logic        tx_active
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  tx_state_e      state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [7:0]     sh, sh_nxt;
  logic           txd_nxt;
  logic           wr_pend;
  logic           overflow;
  logic           fifo_push;
  logic           fifo_pop;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic           unused_wr_bits;

  assign unused_wr_bits = ^wr_data[14:8];
  assign fifo_push = wr_pend && !wr_data[CTL_FLAG];

  byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .din      (wr_data[7:0]),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_pend  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_pend <= wr_load;
      if (fifo_push && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_pend && wr_data[CTL_FLAG] && wr_data[CTL_CLR_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    txd_nxt   = txd;
    fifo_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        txd_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          sh_nxt    = fifo_dout;
          cnt_nxt   = CNT_LOAD;
          txd_nxt   = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_nxt   = CNT_LOAD;
          idx_nxt   = 3'd0;
          txd_nxt   = sh[0];
          state_nxt = S_DATA;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_nxt = CNT_LOAD;
          if (idx == 3'd7) begin
            txd_nxt   = 1'b1;
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx + 3'd1;
            txd_nxt = sh[idx_nxt];
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sh_nxt    = fifo_dout;
            cnt_nxt   = CNT_LOAD;
            txd_nxt   = 1'b0;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        txd_nxt   = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      txd       <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      sh        <= sh_nxt;
      txd       <= txd_nxt;
      tx_active <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    status = '0;
    status[ST_FULL]   = fifo_full;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_ACTIVE] = tx_active;
    status[ST_OVF]    = overflow;
    status[ST_COUNT_LSB +: FIFO_AW+1] = fifo_count;
  end

endmodule
